// File: rtl/ipcore_drop_filter_pkg.sv
// ipcore_drop_filter_pkg
// Shared types and constants for the drop filter slice.
//   rd_state_t    : read-side FSM state encoding (3 bits)
//   DECISION_DROP : value of decision bit0 that discards a packet
package ipcore_drop_filter_pkg;

  typedef enum logic [2:0] {
    RD_IDLE        = 3'd0,
    RD_FWD         = 3'd1,
    RD_DROP        = 3'd2,
    RD_FLUSH       = 3'd3,
    RD_DISCARD_DEC = 3'd4
  } rd_state_t;

  localparam logic DECISION_DROP = 1'b1;

endpackage

// File: rtl/ipcore_drop_filter_if.sv
// ipcore_drop_filter_if
// Stream handshake bundle used for the word input, the decision input and
// the word output of the drop filter.
//   tdata  [W-1:0] : payload
//   tvalid         : payload valid (master -> slave)
//   tlast          : last beat of a packet (master -> slave)
//   tready         : slave can accept (slave -> master)
interface ipcore_drop_filter_if #(
  parameter int W = 512
) ();

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/ipcore_drop_filter_fifo.sv
// ipcore_fwft_fifo
// Synchronous first-word-fall-through FIFO. A written word is visible on
// dout one cycle after the write edge. Simultaneous read and write are
// allowed whenever the FIFO is not empty.
//   aclk, aresetn : clock, synchronous active-low reset (empties the FIFO)
//   wr_en, din    : push request and data (ignored while full)
//   full          : DEPTH words stored
//   rd_en         : pop request (ignored while empty)
//   dout, valid   : head word and head-present flag
module ipcore_fwft_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 64
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && valid;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ipcore_drop_filter.sv
// ipcore_drop_filter
// Buffers each packet until its drop/forward decision arrives, then either
// streams the packet out or discards it. Packets longer than the FIFO are
// flushed, counted as dropped and flagged via a sticky error.
//   aclk, aresetn  : clock, synchronous active-low reset
//   s_word         : packet words in (slave)
//   s_decision     : per-packet decision in, tdata[0]=1 drops (slave)
//   m_word         : forwarded packet words out (master)
//   stat_fwd_pkts  : forwarded packet count (wraps)
//   stat_drop_pkts : dropped packet count incl. oversize (wraps)
//   err_oversize   : sticky, a packet exceeded DEPTH words
//
// state          | meaning
// RD_IDLE        | wait for a complete packet and its decision
// RD_FWD         | stream head packet to m_word
// RD_DROP        | discard head packet, one word per cycle
// RD_FLUSH       | oversize packet: discard words until its tlast
// RD_DISCARD_DEC | swallow the oversize packet's decision
module ipcore_drop_filter
  import ipcore_drop_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  ipcore_drop_filter_if.slave  s_word,
  ipcore_drop_filter_if.slave  s_decision,
  ipcore_drop_filter_if.master m_word,
  output logic [CNT_WIDTH-1:0] stat_fwd_pkts,
  output logic [CNT_WIDTH-1:0] stat_drop_pkts,
  output logic                 err_oversize
);

  localparam int PCW = $clog2(DEPTH) + 1;

  rd_state_t         state;
  rd_state_t         state_nxt;

  logic              fifo_wr;
  logic              fifo_full;
  logic              fifo_rd;
  logic              fifo_valid;
  logic [DATA_WIDTH:0] fifo_dout;
  logic              head_last;

  logic [PCW-1:0]    pkt_count;
  logic              pkt_in;
  logic              pkt_out;

  logic              dec_ready;
  logic              dec_fire;
  logic              m_valid;
  logic              fwd_done;
  logic              drop_done;
  logic              oversize;

  // The decision stream's tlast carries no meaning here.
  logic              unused_dec_tlast;
  assign unused_dec_tlast = s_decision.tlast;

  assign s_word.tready = aresetn && !fifo_full;
  assign fifo_wr       = s_word.tvalid && s_word.tready;
  assign head_last     = fifo_dout[DATA_WIDTH];

  ipcore_fwft_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (fifo_wr),
    .din     ({s_word.tlast, s_word.tdata}),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .dout    (fifo_dout),
    .valid   (fifo_valid)
  );

  // Complete packets held in the FIFO; a decision is only accepted when
  // the packet it belongs to has fully arrived.
  assign pkt_in  = fifo_wr && s_word.tlast;
  assign pkt_out = fifo_rd && head_last;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pkt_count <= '0;
    end else if (pkt_in && !pkt_out) begin
      pkt_count <= pkt_count + 1'b1;
    end else if (pkt_out && !pkt_in) begin
      pkt_count <= pkt_count - 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= RD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign dec_fire = s_decision.tvalid && dec_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RD_IDLE: begin
        if (oversize) begin
          state_nxt = RD_FLUSH;
        end else if (dec_fire) begin
          state_nxt = (s_decision.tdata[0] == DECISION_DROP) ? RD_DROP : RD_FWD;
        end
      end
      RD_FWD:         if (fwd_done)  state_nxt = RD_IDLE;
      RD_DROP:        if (drop_done) state_nxt = RD_IDLE;
      RD_FLUSH:       if (drop_done) state_nxt = RD_DISCARD_DEC;
      RD_DISCARD_DEC: if (dec_fire)  state_nxt = RD_IDLE;
      default:        state_nxt = RD_IDLE;
    endcase
  end

  // All handshake outputs are forced low while aresetn is held low, since
  // the state register only clears on the reset edge.
  always_comb begin
    fifo_rd   = 1'b0;
    m_valid   = 1'b0;
    dec_ready = 1'b0;
    fwd_done  = 1'b0;
    drop_done = 1'b0;
    oversize  = 1'b0;
    if (aresetn) begin
      unique case (state)
        RD_IDLE: begin
          // A full FIFO with no complete packet can never drain otherwise.
          oversize  = fifo_full && (pkt_count == '0);
          dec_ready = (pkt_count != '0);
        end
        RD_FWD: begin
          m_valid  = fifo_valid;
          fifo_rd  = fifo_valid && m_word.tready;
          fwd_done = fifo_rd && head_last;
        end
        RD_DROP, RD_FLUSH: begin
          fifo_rd   = fifo_valid;
          drop_done = fifo_rd && head_last;
        end
        RD_DISCARD_DEC: begin
          dec_ready = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign m_word.tvalid    = m_valid;
  assign m_word.tdata     = fifo_dout[DATA_WIDTH-1:0];
  assign m_word.tlast     = head_last;
  assign s_decision.tready = dec_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_fwd_pkts  <= '0;
      stat_drop_pkts <= '0;
      err_oversize   <= 1'b0;
    end else begin
      if (fwd_done) begin
        stat_fwd_pkts <= stat_fwd_pkts + CNT_WIDTH'(1);
      end
      if (drop_done) begin
        stat_drop_pkts <= stat_drop_pkts + CNT_WIDTH'(1);
      end
      if (oversize) begin
        err_oversize <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ipcore_drop_filter.sv
// tb_ipcore_drop_filter
// Self-checking bench for ipcore_drop_filter. A packet-level model (queues of
// expected output words, expected stat counts) is built from the stimulus.
module tb_ipcore_drop_filter;

  localparam int DW    = 512;
  localparam int DEPTH = 64;
  localparam int CW    = 32;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  ipcore_drop_filter_if #(.W(DW)) s_word ();
  ipcore_drop_filter_if #(.W(1))  s_decision ();
  ipcore_drop_filter_if #(.W(DW)) m_word ();

  logic [CW-1:0] stat_fwd_pkts;
  logic [CW-1:0] stat_drop_pkts;
  logic          err_oversize;

  ipcore_drop_filter #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_word         (s_word),
    .s_decision     (s_decision),
    .m_word         (m_word),
    .stat_fwd_pkts  (stat_fwd_pkts),
    .stat_drop_pkts (stat_drop_pkts),
    .err_oversize   (err_oversize)
  );

  int n_checks   = 0;
  int n_fail     = 0;
  int to_err     = 0;
  int stall_viol = 0;
  int exp_fwd    = 0;
  int exp_drop   = 0;

  logic [DW:0] obs_q[$];
  logic [DW:0] exp_q[$];

  // ready pattern: 0 = fixed rdy_val, 1 = random, 2 = repeating 1,0,0,1
  int   rdy_mode = 0;
  logic rdy_val  = 1'b1;
  int   pat_idx  = 0;

  initial begin
    m_word.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (rdy_mode == 1) begin
        m_word.tready = 1'($urandom_range(0, 1));
      end else if (rdy_mode == 2) begin
        m_word.tready = !((pat_idx % 4 == 1) || (pat_idx % 4 == 2));
        pat_idx++;
      end else begin
        m_word.tready = rdy_val;
      end
    end
  end

  // Output monitor: records accepted words, counts stall-stability breaks.
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_word;
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_word.tvalid || ({m_word.tlast, m_word.tdata} !== prev_word)))
        stall_viol++;
      if (m_word.tvalid && m_word.tready)
        obs_q.push_back({m_word.tlast, m_word.tdata});
      prev_stall = m_word.tvalid && !m_word.tready;
      prev_word  = {m_word.tlast, m_word.tdata};
    end
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    int k = 0;
    s_word.tdata  = d;
    s_word.tlast  = last;
    s_word.tvalid = 1'b1;
    while (!s_word.tready && k < 3000) begin
      tick(1);
      k++;
    end
    if (k >= 3000) to_err++;
    tick(1);
    s_word.tvalid = 1'b0;
  endtask

  task automatic send_dec(input logic drop);
    int k = 0;
    s_decision.tdata  = drop;
    s_decision.tlast  = 1'b1;
    s_decision.tvalid = 1'b1;
    while (!s_decision.tready && k < 3000) begin
      tick(1);
      k++;
    end
    if (k >= 3000) to_err++;
    tick(1);
    s_decision.tvalid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int k = 0;
    while (obs_q.size() < n && k < 2000) begin
      tick(1);
      k++;
    end
    tick(2);
  endtask

  task automatic test_reset();
    s_word.tvalid = 1'b0; s_word.tlast = 1'b0; s_word.tdata = '0;
    s_decision.tvalid = 1'b0; s_decision.tlast = 1'b0; s_decision.tdata = '0;
    aresetn = 1'b0;
    tick(3);
    n_checks++;
    if (s_word.tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_word_tready got=%b exp=0", s_word.tready); end
    n_checks++;
    if (m_word.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid got=%b exp=0", m_word.tvalid); end
    n_checks++;
    if (s_decision.tready !== 1'b0) begin n_fail++; $display("FAIL rst_dec_tready got=%b exp=0", s_decision.tready); end
    aresetn = 1'b1;
    tick(1);
    n_checks++;
    if (s_word.tready !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_word_tready got=%b exp=1", s_word.tready); end
    n_checks++;
    if (stat_fwd_pkts !== '0 || stat_drop_pkts !== '0 || err_oversize !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_stats got fwd=%0d drop=%0d err=%b exp 0/0/0", stat_fwd_pkts, stat_drop_pkts, err_oversize);
    end
    n_checks++;
    if (s_decision.tready !== 1'b0) begin n_fail++; $display("FAIL post_rst_dec_tready got=%b exp=0", s_decision.tready); end
  endtask

  task automatic test_forward();
    obs_q.delete(); exp_q.delete();
    rdy_mode = 0; rdy_val = 1'b1;
    send_word(DW'(1), 1'b0);
    send_word(DW'(2), 1'b0);
    n_checks++;
    if (s_decision.tready !== 1'b0) begin n_fail++; $display("FAIL fwd_early_dec_held got=%b exp=0", s_decision.tready); end
    send_word(DW'(3), 1'b1);
    for (int i = 1; i <= 3; i++) exp_q.push_back({(i == 3), DW'(i)});
    send_dec(1'b0);
    n_checks++;
    if (m_word.tvalid !== 1'b1) begin n_fail++; $display("FAIL fwd_latency m_tvalid got=%b exp=1", m_word.tvalid); end
    wait_obs(3);
    exp_fwd++;
    n_checks++;
    if (obs_q.size() !== 3) begin n_fail++; $display("FAIL fwd_count got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fwd_word%0d got=%h exp=%h", i, obs_q[i][15:0], exp_q[i][15:0]); end
    end
    n_checks++;
    if (obs_q.size() == 3 && obs_q[2][DW] !== 1'b1) begin n_fail++; $display("FAIL fwd_tlast got=0 exp=1"); end
    n_checks++;
    if (stat_fwd_pkts !== CW'(exp_fwd)) begin n_fail++; $display("FAIL fwd_stat got=%0d exp=%0d", stat_fwd_pkts, exp_fwd); end
  endtask

  task automatic test_drop();
    logic [DW-1:0] w0, w1;
    obs_q.delete();
    for (int i = 1; i <= 3; i++) send_word(DW'(i), (i == 3));
    send_dec(1'b1);
    tick(4);
    exp_drop++;
    n_checks++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL drop_no_output got=%0d words exp=0", obs_q.size()); end
    n_checks++;
    if (stat_drop_pkts !== CW'(exp_drop)) begin n_fail++; $display("FAIL drop_stat got=%0d exp=%0d", stat_drop_pkts, exp_drop); end
    n_checks++;
    if (s_decision.tready !== 1'b0) begin n_fail++; $display("FAIL drop_dec_tready_idle got=%b exp=0", s_decision.tready); end
    w0 = rand_word(); w1 = rand_word();
    send_word(w0, 1'b0);
    n_checks++;
    if (s_decision.tready !== 1'b0) begin n_fail++; $display("FAIL drop_dec_tready_partial got=%b exp=0", s_decision.tready); end
    send_word(w1, 1'b1);
    n_checks++;
    if (s_decision.tready !== 1'b1) begin n_fail++; $display("FAIL drop_dec_tready_complete got=%b exp=1", s_decision.tready); end
    send_dec(1'b0);
    wait_obs(2);
    exp_fwd++;
    n_checks++;
    if (obs_q.size() !== 2 || obs_q[0] !== {1'b0, w0} || obs_q[1] !== {1'b1, w1}) begin
      n_fail++; $display("FAIL drop_followup_pkt got %0d words exp 2 matching", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a [2];
    logic [DW-1:0] b [4];
    obs_q.delete();
    foreach (a[i]) a[i] = rand_word();
    foreach (b[i]) b[i] = rand_word();
    for (int i = 0; i < 2; i++) send_word(a[i], (i == 1));
    for (int i = 0; i < 4; i++) send_word(b[i], (i == 3));
    send_dec(1'b1);
    send_dec(1'b0);
    wait_obs(4);
    exp_drop++; exp_fwd++;
    n_checks++;
    if (obs_q.size() !== 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {(i == 3), b[i]}) begin n_fail++; $display("FAIL b2b_word%0d got=%h exp=%h", i, obs_q[i][15:0], b[i][15:0]); end
    end
    n_checks++;
    if (stat_fwd_pkts !== CW'(exp_fwd) || stat_drop_pkts !== CW'(exp_drop)) begin
      n_fail++; $display("FAIL b2b_stats got fwd=%0d drop=%0d exp fwd=%0d drop=%0d", stat_fwd_pkts, stat_drop_pkts, exp_fwd, exp_drop);
    end
    n_checks++;
    if (s_decision.tready !== 1'b0) begin n_fail++; $display("FAIL b2b_pkt_count_zero dec_tready got=%b exp=0", s_decision.tready); end
  endtask

  task automatic test_stall_random();
    int          npk = 12;
    int          lens[$];
    logic        decs[$];
    logic [DW:0] words[$];
    int          viol0 = stall_viol;
    int          to0   = to_err;
    obs_q.delete(); exp_q.delete();
    pat_idx = 0;
    rdy_mode = 2;
    for (int p = 0; p < npk; p++) begin
      int   len = (p == 0) ? 6 : $urandom_range(1, 8);
      logic d   = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      lens.push_back(len);
      decs.push_back(d);
      for (int i = 0; i < len; i++) begin
        logic [DW:0] w = {(i == len - 1), rand_word()};
        words.push_back(w);
        if (!d) exp_q.push_back(w);
      end
      if (d) exp_drop++; else exp_fwd++;
    end
    fork
      begin
        for (int i = 0; i < words.size(); i++) send_word(words[i][DW-1:0], words[i][DW]);
      end
      begin
        for (int p = 0; p < npk; p++) begin
          send_dec(decs[p]);
          if (p == 0) rdy_mode = 1;
        end
      end
    join
    wait_obs(exp_q.size());
    rdy_mode = 0; rdy_val = 1'b1;
    tick(2);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word%0d got=%h exp=%h", i, obs_q[i][15:0], exp_q[i][15:0]); end
    end
    n_checks++;
    if (stall_viol !== viol0) begin n_fail++; $display("FAIL rand_stall_stable got=%0d violations exp=%0d", stall_viol, viol0); end
    n_checks++;
    if (to_err !== to0) begin n_fail++; $display("FAIL rand_timeout got=%0d exp=%0d", to_err, to0); end
    n_checks++;
    if (stat_fwd_pkts !== CW'(exp_fwd) || stat_drop_pkts !== CW'(exp_drop)) begin
      n_fail++; $display("FAIL rand_stats got fwd=%0d drop=%0d exp fwd=%0d drop=%0d", stat_fwd_pkts, stat_drop_pkts, exp_fwd, exp_drop);
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] w [DEPTH];
    obs_q.delete();
    foreach (w[i]) w[i] = rand_word();
    for (int i = 0; i < DEPTH - 1; i++) send_word(w[i], 1'b0);
    n_checks++;
    if (s_word.tready !== 1'b1) begin n_fail++; $display("FAIL full_at_depth_minus1 tready got=%b exp=1", s_word.tready); end
    send_word(w[DEPTH-1], 1'b1);
    n_checks++;
    if (s_word.tready !== 1'b0) begin n_fail++; $display("FAIL full_at_depth tready got=%b exp=0", s_word.tready); end
    tick(2);
    n_checks++;
    if (err_oversize !== 1'b0) begin n_fail++; $display("FAIL full_no_oversize got=%b exp=0", err_oversize); end
    send_dec(1'b0);
    wait_obs(DEPTH);
    exp_fwd++;
    n_checks++;
    if (obs_q.size() !== DEPTH) begin n_fail++; $display("FAIL full_count got=%0d exp=%0d", obs_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== {(i == DEPTH - 1), w[i]}) begin n_fail++; $display("FAIL full_word%0d got=%h exp=%h", i, obs_q[i][15:0], w[i][15:0]); end
    end
  endtask

  task automatic test_oversize();
    logic [DW-1:0] w0, w1;
    int to0 = to_err;
    obs_q.delete();
    for (int i = 0; i < DEPTH - 1; i++) send_word(rand_word(), 1'b0);
    n_checks++;
    if (err_oversize !== 1'b0) begin n_fail++; $display("FAIL ovs_err_early got=%b exp=0", err_oversize); end
    send_word(rand_word(), 1'b0);
    tick(1);
    n_checks++;
    if (err_oversize !== 1'b1) begin n_fail++; $display("FAIL ovs_err_at_depth got=%b exp=1", err_oversize); end
    for (int i = 0; i < 5; i++) send_word(rand_word(), (i == 4));
    send_dec(1'b0);
    tick(4);
    exp_drop++;
    n_checks++;
    if (to_err !== to0) begin n_fail++; $display("FAIL ovs_absorb_timeout got=%0d exp=%0d", to_err, to0); end
    n_checks++;
    if (obs_q.size() !== 0) begin n_fail++; $display("FAIL ovs_no_output got=%0d exp=0", obs_q.size()); end
    n_checks++;
    if (stat_drop_pkts !== CW'(exp_drop) || stat_fwd_pkts !== CW'(exp_fwd)) begin
      n_fail++; $display("FAIL ovs_stats got fwd=%0d drop=%0d exp fwd=%0d drop=%0d", stat_fwd_pkts, stat_drop_pkts, exp_fwd, exp_drop);
    end
    w0 = rand_word(); w1 = rand_word();
    send_word(w0, 1'b0);
    send_word(w1, 1'b1);
    send_dec(1'b0);
    wait_obs(2);
    exp_fwd++;
    n_checks++;
    if (obs_q.size() !== 2 || obs_q[0] !== {1'b0, w0} || obs_q[1] !== {1'b1, w1}) begin
      n_fail++; $display("FAIL ovs_followup_pkt got %0d words exp 2 matching", obs_q.size());
    end
    n_checks++;
    if (err_oversize !== 1'b1 || stat_fwd_pkts !== CW'(exp_fwd)) begin
      n_fail++; $display("FAIL ovs_sticky got err=%b fwd=%0d exp err=1 fwd=%0d", err_oversize, stat_fwd_pkts, exp_fwd);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w0, w1;
    obs_q.delete();
    rdy_mode = 0; rdy_val = 1'b1;
    for (int i = 0; i < 4; i++) send_word(rand_word(), (i == 3));
    send_dec(1'b0);
    tick(1);
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (m_word.tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_tvalid_during got=%b exp=0", m_word.tvalid); end
    tick(1);
    aresetn = 1'b1;
    exp_fwd = 0; exp_drop = 0;
    #1;
    n_checks++;
    if (m_word.tvalid !== 1'b0 || s_decision.tready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle got tvalid=%b dec_tready=%b exp 0/0", m_word.tvalid, s_decision.tready);
    end
    n_checks++;
    if (stat_fwd_pkts !== '0 || stat_drop_pkts !== '0 || err_oversize !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_stats got fwd=%0d drop=%0d err=%b exp 0/0/0", stat_fwd_pkts, stat_drop_pkts, err_oversize);
    end
    tick(3);
    obs_q.delete();
    w0 = rand_word(); w1 = rand_word();
    send_word(w0, 1'b0);
    send_word(w1, 1'b1);
    send_dec(1'b0);
    wait_obs(2);
    exp_fwd++;
    n_checks++;
    if (obs_q.size() !== 2 || obs_q[0] !== {1'b0, w0} || obs_q[1] !== {1'b1, w1}) begin
      n_fail++; $display("FAIL rstmid_fifo_empty got %0d words exp 2 matching", obs_q.size());
    end
    n_checks++;
    if (stat_fwd_pkts !== CW'(exp_fwd)) begin n_fail++; $display("FAIL rstmid_fwd_stat got=%0d exp=%0d", stat_fwd_pkts, exp_fwd); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_drop();
    test_back_to_back();
    test_stall_random();
    test_full();
    test_oversize();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ipcore_drop_filter.md
Name: ipcore_drop_filter

Overview:
- Sits directly downstream of the user-processing stage.
- Buffers each packet's 512-bit words in a FIFO until the per-packet drop decision arrives, which always comes after that packet's last word.
- On the decision it either forwards the whole buffered packet to the output stream or discards it.
- Keeps forwarded/dropped counters and detects packets too long to buffer.

Parameters:
DATA_WIDTH, 512, word width of s_word/m_word tdata
DEPTH, 64, packet FIFO depth in words (power of 2, >=4); maximum supported packet length
CNT_WIDTH, 32, width of statistics counters

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_word_tdata  in  DATA_WIDTH  packet word from processing stage
s_word_tvalid  in  1  word valid
s_word_tlast  in  1  last word of packet
s_word_tready  out  1  = !fifo_full
s_decision_tdata  in  1  bit0: 1=drop, 0=forward
s_decision_tvalid  in  1  decision valid
s_decision_tlast  in  1  ignored
s_decision_tready  out  1  decision accepted
m_word_tdata  out  DATA_WIDTH  forwarded word
m_word_tvalid  out  1  forwarded word valid
m_word_tlast  out  1  last word of forwarded packet
m_word_tready  in  1  downstream ready
stat_fwd_pkts  out  CNT_WIDTH  packets forwarded, wraps
stat_drop_pkts  out  CNT_WIDTH  packets dropped (by decision or oversize), wraps
err_oversize  out  1  sticky: a packet exceeded DEPTH words

Behaviour:
- Reset is synchronous: aresetn low on a rising aclk edge. It empties the FIFO, clears pkt_count, sets state RD_IDLE, clears both stat counters and err_oversize.
- During and after reset: s_word_tready=0 while aresetn low; m_word_tvalid=0; s_decision_tready=0.
- A mid-packet reset discards all buffered words. Any words already accepted upstream are lost; no partial packet is emitted.
- Write side:
  - Push {tlast,tdata} when s_word_tvalid && s_word_tready.
  - There is no write-through-read when full; s_word_tready depends only on fifo_full.
- pkt_count counts complete packets (tlast words) present in the FIFO:
  - +1 on a tlast word written.
  - -1 on a tlast word popped.
  - Both in the same cycle leaves it unchanged.
  - Width is clog2(DEPTH)+1.
- Read-side FSM:
  - RD_IDLE:
    - s_decision_tready = (pkt_count>0).
    - On a decision handshake with bit0=0, go to RD_FWD; with bit0=1, go to RD_DROP.
    - If fifo_full && pkt_count==0, set err_oversize=1 and go to RD_FLUSH. This check has priority; no decision can be accepted in that state anyway.
  - RD_FWD:
    - m_word_tvalid = fifo_valid; m_word_tdata/tlast = FIFO head.
    - Pop on m_word_tvalid && m_word_tready.
    - On popping tlast: stat_fwd_pkts+1, go to RD_IDLE.
  - RD_DROP:
    - Pop one word per cycle while fifo_valid; m_word_tvalid stays 0.
    - On popping tlast: stat_drop_pkts+1, go to RD_IDLE.
  - RD_FLUSH:
    - Pop unconditionally while fifo_valid; writes continue.
    - On popping tlast: stat_drop_pkts+1, go to RD_DISCARD_DEC.
  - RD_DISCARD_DEC:
    - s_decision_tready=1.
    - On handshake, ignore the value and go to RD_IDLE. This consumes the oversize packet's decision.
- Latency:
  - Decision handshake in cycle N gives the first m_word_tvalid in cycle N+1, provided the head word is present, which is guaranteed since pkt_count>0.
  - Word-in to FIFO head: 1 cycle (FWFT).
- Throughput:
  - 1 word/cycle in RD_FWD with m_word_tready held high.
  - After a packet, 1 idle cycle in RD_IDLE before the next decision is accepted.
- m_word_tvalid never depends combinationally on m_word_tready. Once asserted it holds with stable data until the handshake, because the FIFO head only changes on pop.
- Decisions arrive in packet order, exactly one per packet. An early decision (pkt_count==0) is held off by tready=0.
- Counters wrap modulo 2^CNT_WIDTH. err_oversize clears only on reset.

Decomposition:
- Package ipcore_drop_filter_pkg holds:
  - read FSM state encoding (RD_IDLE, RD_FWD, RD_DROP, RD_FLUSH, RD_DISCARD_DEC), 3 bits;
  - DECISION_DROP=1'b1 constant.
- Sub-module ipcore_fwft_fifo: synchronous first-word-fall-through FIFO.
  - Width DATA_WIDTH+1, depth DEPTH.
  - Ports: wr_en, din, full, rd_en, dout, valid.
  - Read and write in the same cycle are legal when not empty.
- The top level contains the FSM, pkt_count, stats and handshake glue.

Test Plan:
- 3-word packet (tdata 0x1,0x2,0x3, tlast on 3rd), then decision 0 -> m_word emits 0x1,0x2,0x3 with tlast on 0x3; first m_word_tvalid 1 cycle after decision handshake; stat_fwd_pkts=1.
- Same packet with decision 1 -> no m_word_tvalid; FIFO empty after 3 cycles; stat_drop_pkts=1; s_decision_tready low until the next packet's tlast is written.
- Back-to-back packets A(2 words), B(4 words) written before any decision; decisions 1 then 0 -> only B's 4 words appear; stat_drop_pkts=1, stat_fwd_pkts=1; pkt_count returns to 0.
- m_word_tready toggled 1,0,0,1 in RD_FWD -> tdata/tlast held stable while stalled; no word lost or duplicated; s_word_tready drops exactly when the FIFO holds DEPTH words.
- Packet of DEPTH+5 words (DEPTH=64), then decision 0 -> err_oversize=1 when 64 words are buffered; all 69 words absorbed; no output; decision consumed; stat_drop_pkts=1; a following 2-word packet with decision 0 forwards normally.
- aresetn low for 1 cycle midway through forwarding a 4-word packet -> next cycle m_word_tvalid=0, FIFO empty, stats 0, err_oversize 0, state RD_IDLE.
